// File: rtl/decode_stage.sv
// decode_stage: registered RV32/RV64 decode stage with a 2-entry skid buffer and flush
module decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_shamt,
  output logic [2:0]      out_type,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_writeback,
  output logic            out_is_r_type,
  output logic            out_is_word,
  output logic            out_illegal
);
  localparam logic [2:0] TYPE_R = 3'd0, TYPE_I = 3'd1, TYPE_S = 3'd2,
                         TYPE_B = 3'd3, TYPE_U = 3'd4, TYPE_J = 3'd5;
  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_OP = 7'b0110011,
                         OPC_OP_IMM = 7'b0010011, OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_MISC_MEM = 7'b0001111, OPC_SYSTEM = 7'b1110011,
                         OPC_OP_IMM_32 = 7'b0011011, OPC_OP_32 = 7'b0111011;
  localparam bit RV64 = (XLEN == 64);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end

  // raw inst is kept so field slices come straight from the held word
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic            ld;
    logic            st;
    logic            wb;
    logic            word;
    logic            ill;
  } ent_t;

  ent_t dec, m_q, m_d, k_q, k_d;
  logic m_valid_q, m_valid_d, k_valid_q, k_valid_d;
  logic [31:0] imm32;
  logic acc, m_free;

  // decode the incoming word into type, flags and immediate
  always_comb begin
    dec      = '0;
    dec.pc   = in_pc;
    dec.inst = in_inst;
    dec.typ  = TYPE_I;
    case (in_inst[6:0])
      OPC_LUI, OPC_AUIPC:       begin dec.typ = TYPE_U; dec.wb = 1'b1; end
      OPC_OP:                   begin dec.typ = TYPE_R; dec.wb = 1'b1; end
      OPC_OP_IMM, OPC_JALR:     dec.wb = 1'b1;
      OPC_JAL:                  begin dec.typ = TYPE_J; dec.wb = 1'b1; end
      OPC_BRANCH:               dec.typ = TYPE_B;
      OPC_LOAD:                 begin dec.ld = 1'b1; dec.wb = 1'b1; end
      OPC_STORE:                begin dec.typ = TYPE_S; dec.st = 1'b1; end
      OPC_MISC_MEM, OPC_SYSTEM: dec.typ = TYPE_I;
      OPC_OP_IMM_32:            begin dec.wb = RV64; dec.word = RV64; dec.ill = !RV64; end
      OPC_OP_32:                begin dec.typ = RV64 ? TYPE_R : TYPE_I; dec.wb = RV64; dec.word = RV64; dec.ill = !RV64; end
      default:                  dec.ill = 1'b1;
    endcase
    imm32 = dec.typ == TYPE_I ? {{20{in_inst[31]}}, in_inst[31:20]} :
            dec.typ == TYPE_S ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
            dec.typ == TYPE_B ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
            dec.typ == TYPE_U ? {in_inst[31:12], 12'b0} :
            dec.typ == TYPE_J ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
            32'd0;
    dec.imm = XLEN'($signed(imm32));
  end

  // skid control: M refills from K first; new beats go to M only when K is empty
  always_comb begin
    m_free    = !m_valid_q || out_ready;
    acc       = in_valid && !k_valid_q;
    m_d       = m_q;
    k_d       = k_q;
    m_valid_d = m_valid_q;
    k_valid_d = k_valid_q;
    if (flush) begin
      m_valid_d = 1'b0;
      k_valid_d = 1'b0;
    end else if (m_free && k_valid_q) begin
      m_d       = k_q;
      m_valid_d = 1'b1;
      k_valid_d = 1'b0;
    end else if (m_free) begin
      m_valid_d = acc;
      m_d       = acc ? dec : m_q;
    end else if (acc) begin
      k_d       = dec;
      k_valid_d = 1'b1;
    end
  end

  // main and skid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q       <= '0;
      k_q       <= '0;
      m_valid_q <= 1'b0;
      k_valid_q <= 1'b0;
    end else begin
      m_q       <= m_d;
      k_q       <= k_d;
      m_valid_q <= m_valid_d;
      k_valid_q <= k_valid_d;
    end
  end

  assign in_ready         = !k_valid_q;
  assign out_valid        = m_valid_q;
  assign out_pc           = m_q.pc;
  assign out_opcode       = m_q.inst[6:0];
  assign out_rd           = m_q.inst[11:7];
  assign out_rs           = m_q.inst[19:15];
  assign out_rs2          = m_q.inst[24:20];
  assign out_funct3       = m_q.inst[14:12];
  assign out_funct7       = m_q.inst[31:25];
  assign out_imm          = m_q.imm;
  assign out_shamt        = RV64 ? m_q.inst[25:20] : {1'b0, m_q.inst[24:20]};
  assign out_type         = m_q.typ;
  assign out_is_load      = m_q.ld;
  assign out_is_store     = m_q.st;
  assign out_is_writeback = m_q.wb;
  assign out_is_r_type    = m_valid_q && m_q.typ == TYPE_R;
  assign out_is_word      = m_q.word;
  assign out_illegal      = m_q.ill;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage for XLEN=64 and XLEN=32
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_pc = '0, in_inst = '0;
  logic a_in_ready, a_out_valid, a_ld, a_st, a_wb, a_rt, a_wd, a_il;
  logic b_in_ready, b_out_valid, b_ld, b_st, b_wb, b_rt, b_wd, b_il;
  logic [31:0] a_pc, b_pc, b_imm;
  logic [63:0] a_imm;
  logic [6:0] a_opc, b_opc, a_f7, b_f7;
  logic [4:0] a_rd, a_rs, a_rs2, b_rd, b_rs, b_rs2;
  logic [2:0] a_f3, b_f3, a_ty, b_ty;
  logic [5:0] a_sh, b_sh;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_opc), .out_rd(a_rd), .out_rs(a_rs), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm), .out_shamt(a_sh), .out_type(a_ty),
    .out_is_load(a_ld), .out_is_store(a_st), .out_is_writeback(a_wb), .out_is_r_type(a_rt),
    .out_is_word(a_wd), .out_illegal(a_il));

  decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_opc), .out_rd(b_rd), .out_rs(b_rs), .out_rs2(b_rs2),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm), .out_shamt(b_sh), .out_type(b_ty),
    .out_is_load(b_ld), .out_is_store(b_st), .out_is_writeback(b_wb), .out_is_r_type(b_rt),
    .out_is_word(b_wd), .out_illegal(b_il));

  // record every pc handed downstream by the 64-bit instance
  always @(posedge clk) if (a_out_valid && out_ready) q.push_back(a_pc);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] pc, input logic [31:0] inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_valid", a_out_valid, 0);
    chk("rst_ready", a_in_ready, 1);
    chk("rst_imm", a_imm, 0);
    #4 rst = 1'b0;
    step();
    beat(32'h10, 32'hFFF00093);
    chk("addi_valid", a_out_valid, 1);
    chk("addi_pc", a_pc, 32'h10);
    chk("addi_type", a_ty, 1);
    chk("addi_rd", a_rd, 1);
    chk("addi_imm64", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_imm32", b_imm, 32'hFFFF_FFFF);
    chk("addi_wb", a_wb, 1);
    chk("addi_ill", a_il, 0);
    beat(32'h14, 32'hFE112E23);
    chk("sw_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_type", a_ty, 2);
    chk("sw_store", a_st, 1);
    chk("sw_wb", a_wb, 0);
    beat(32'h18, 32'hFE000EE3);
    chk("beq_imm", a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_type", a_ty, 3);
    chk("beq_wb", a_wb, 0);
    beat(32'h1C, 32'h800000B7);
    chk("lui_imm64", a_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", b_imm, 32'h8000_0000);
    chk("lui_type", a_ty, 4);
    chk("lui_wb", a_wb, 1);
    beat(32'h20, 32'h0080006F);
    chk("jal_imm", a_imm, 8);
    chk("jal_type", a_ty, 5);
    beat(32'h24, 32'h002081B3);
    chk("add_type", a_ty, 0);
    chk("add_imm", a_imm, 0);
    chk("add_rt", a_rt, 1);
    chk("add_regs", {a_rd, a_rs, a_rs2}, {5'd3, 5'd1, 5'd2});
    beat(32'h28, 32'h00402083);
    chk("lw_load", a_ld, 1);
    chk("lw_wb", a_wb, 1);
    chk("lw_imm", a_imm, 4);
    beat(32'h2C, 32'h0010009B);
    chk("addiw64_word", a_wd, 1);
    chk("addiw64_wb", a_wb, 1);
    chk("addiw64_ill", a_il, 0);
    chk("addiw32_ill", b_il, 1);
    chk("addiw32_wb", b_wb, 0);
    chk("addiw32_type", b_ty, 1);
    chk("addiw32_word", b_wd, 0);
    beat(32'h30, 32'h02109093);
    chk("slli64_shamt", a_sh, 33);
    chk("slli32_shamt", b_sh, 1);
    beat(32'h34, 32'h00000000);
    chk("bad_ill", a_il, 1);
    chk("bad_type", a_ty, 1);
    chk("bad_flags", {a_ld, a_st, a_wb}, 0);
    step();
    q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h00100093;
    step();
    chk("bp_first_valid", a_out_valid, 1);
    chk("bp_first_ready", a_in_ready, 1);
    in_pc = 32'h104; in_inst = 32'h00200093;
    step();
    chk("bp_full_ready", a_in_ready, 0);
    in_pc = 32'h108; in_inst = 32'h00300093;
    step();
    chk("bp_hold_ready", a_in_ready, 0);
    chk("bp_hold_pc", a_pc, 32'h100);
    chk("bp_hold_imm", a_imm, 1);
    out_ready = 1'b1;
    step();
    chk("bp_k2m_pc", a_pc, 32'h104);
    chk("bp_k2m_ready", a_in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp_third_pc", a_pc, 32'h108);
    step();
    chk("bp_empty", a_out_valid, 0);
    chk("bp_count", q.size(), 3);
    chk("bp_q0", q[0], 32'h100);
    chk("bp_q1", q[1], 32'h104);
    chk("bp_q2", q[2], 32'h108);
    q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'h00100093;
    step();
    in_pc = 32'h204;
    step();
    chk("fl_full", a_in_ready, 0);
    in_pc = 32'h208; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", a_out_valid, 0);
    chk("fl_ready", a_in_ready, 1);
    in_valid = 1'b1; in_pc = 32'h20C; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_drop_beat", a_out_valid, 0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("fl_nothing_out", q.size(), 0);
    out_ready = 1'b0;
    beat(32'h300, 32'hFFF00093);
    chk("mrst_pre_valid", a_out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", a_out_valid, 0);
    chk("mrst_ready", a_in_ready, 1);
    chk("mrst_imm", a_imm, 0);
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
